// File: rtl/seq_detect_pkg.sv
// Shared constants for the serial pattern detector: default widths and the
// configuration loaded while rst is held.
package seq_detect_pkg;

    localparam int           PAT_W_DEF   = 8;
    localparam int           CNT_W_DEF   = 16;
    localparam logic [31:0]  RST_PAT     = 32'h0;
    localparam int           RST_LEN     = 0;
    localparam logic         RST_OVERLAP = 1'b1;

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating match counter with synchronous clear; clear beats a coincident
// increment. Updates on the same edge as the match, so it tracks z with no lag.
module seq_match_cnt #(
    parameter int W = seq_detect_pkg::CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with runtime pattern/length/overlap; z pulses one cycle
// after the completing bit, no backpressure (x_valid gates input). Counter built only with SEQ_DETECT_CNT_EN.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       x,
    input  logic                       x_valid,
    input  logic                       cfg_load,
    input  logic [PAT_W-1:0]           pat,
    input  logic [$clog2(PAT_W+1)-1:0] pat_len,
    input  logic                       overlap,
    input  logic                       cnt_clr,
    output logic                       z,
    output logic [CNT_W-1:0]           match_cnt
);

    localparam int LW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] history;
    logic [PAT_W-1:0] pat_q;
    logic [LW-1:0]    len_q;
    logic             ovl_q;
    logic [LW-1:0]    fill;

    logic [PAT_W-1:0] hist_next;
    logic [PAT_W-1:0] len_mask;
    logic [LW-1:0]    fill_next;
    logic [LW-1:0]    len_in;
    logic             match;

    always_comb begin
        hist_next = {history[PAT_W-2:0], x};
        fill_next = (fill == LW'(PAT_W)) ? fill : fill + LW'(1);
        len_in    = (pat_len > LW'(PAT_W)) ? LW'(PAT_W) : pat_len;
        len_mask  = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (LW'(i) < len_q);
        end
        // len_q == 0 leaves the mask empty, so the explicit check is what disables detection
        match = x_valid && !cfg_load && (len_q != '0) && (fill_next >= len_q)
                && (((hist_next ^ pat_q) & len_mask) == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            history <= '0;
            fill    <= '0;
            pat_q   <= RST_PAT[PAT_W-1:0];
            len_q   <= LW'(RST_LEN);
            ovl_q   <= RST_OVERLAP;
            z       <= 1'b0;
        end else if (cfg_load) begin
            history <= '0;
            fill    <= '0;
            pat_q   <= pat;
            len_q   <= len_in;
            ovl_q   <= overlap;
            z       <= 1'b0;
        end else if (x_valid) begin
            history <= hist_next;
            fill    <= (match && !ovl_q) ? '0 : fill_next;
            z       <= match;
        end else begin
            z       <= 1'b0;
        end
    end

`ifdef SEQ_DETECT_CNT_EN
    seq_match_cnt #(.W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (match),
        .clr (cnt_clr),
        .cnt (match_cnt)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter PAT_W, default 8: maximum pattern length in bits, legal range 2..32.
REQ-002 SHALL have parameter CNT_W, default 16: match counter width, legal range 2..32.
REQ-003 SHALL have port clk  input  1: single clock, all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port x  input  1: serial data bit.
REQ-006 SHALL have port x_valid  input  1: x is sampled only on edges where x_valid=1.
REQ-007 SHALL have port cfg_load  input  1: single-cycle pulse that latches pat, pat_len and overlap.
REQ-008 SHALL have port pat  input  PAT_W: pattern; bit [L-1] is the oldest bit and bit [0] the newest, where L is the effective length.
REQ-009 SHALL have port pat_len  input  $clog2(PAT_W+1): pattern length L.
REQ-010 SHALL have port overlap  input  1: 1 = overlapping matches, 0 = non-overlapping matches.
REQ-011 SHALL have port cnt_clr  input  1: synchronous clear of match_cnt.
REQ-012 SHALL have port z  output  1: registered match pulse.
REQ-013 SHALL have port match_cnt  output  CNT_W: saturating count of matches.

Function
REQ-014 SHALL hold a PAT_W-bit history shift register; on an accepted bit, history <= {history[PAT_W-2:0], x}.
REQ-015 SHALL hold a fill counter of valid bits since the last clear, saturating at PAT_W.
REQ-016 SHALL declare a match on an accepted bit when fill (including that bit) >= L and the new history[L-1:0] equals the latched pat[L-1:0].
REQ-017 SHALL drive z=1 for exactly the one cycle following the edge that accepted the completing bit, and z=0 otherwise; latency is 1 clock.
REQ-018 SHALL, in non-overlap mode, reset fill to 0 on a match so that the next match needs L fresh bits; in overlap mode fill is unaffected.
REQ-019 SHALL treat latched L=0 as "detector disabled": z never asserts.
REQ-020 SHALL clamp a latched L greater than PAT_W to PAT_W.
REQ-021 SHALL, on cfg_load=1, latch the configuration, clear history and fill, and force z=0 on the next cycle; x is not accepted on that edge even if x_valid=1 (cfg_load wins).
REQ-022 SHALL ignore x on edges where x_valid=0 and leave all state held; z=0 on the following cycle.
REQ-023 SHALL increment match_cnt by 1 on each match and saturate at 2^CNT_W-1 without wrapping.
REQ-024 SHALL give cnt_clr priority over a simultaneous match: match_cnt becomes 0 while z still pulses.
REQ-025 SHALL leave match_cnt unchanged on cfg_load.

Reset
REQ-026 SHALL, while rst=1 and independent of clk, force z=0, match_cnt=0, history=0 and fill=0, and set the latched config to pat=0, L=0 and overlap=1.
REQ-027 SHALL discard any partial match in progress when rst asserts mid-stream; detection restarts from an empty history after release and a cfg_load.

Configuration
REQ-028 SHALL use the macro SEQ_DETECT_CNT_EN: when defined, match_cnt and cnt_clr operate as specified.
REQ-029 SHALL, when SEQ_DETECT_CNT_EN is undefined, keep the match_cnt port but tie it to constant 0, ignore cnt_clr and synthesise no counter logic; z behaviour is identical in both builds.

Structure
REQ-030 SHALL place the default PAT_W and CNT_W constants and the reset-config constants in package seq_detect_pkg.
REQ-031 SHALL implement the saturating counter with clear as sub-module seq_match_cnt, instantiated only under SEQ_DETECT_CNT_EN.

Verification
REQ-032 SHALL cover: pat=0110, L=4, overlap=1, bits 0,1,1,0,1,1,0 -> z pulses after bits 4 and 7, match_cnt=2.
REQ-033 SHALL cover: the same stream with overlap=0 -> a single z pulse after bit 4, match_cnt=1.
REQ-034 SHALL cover: pat=0110, L=4, overlap=1, stream 0,1,1,0 with x_valid=0 for 3 cycles between each bit -> one z pulse after bit 4 only, and z=0 in all idle cycles.
REQ-035 SHALL cover: CNT_W=2, pat=1, L=1, overlap=1, five 1-bits -> five z pulses and match_cnt saturates at 3; a cnt_clr coincident with the sixth match -> match_cnt=0 and z=1.
REQ-036 SHALL cover: L=0 with any stream -> z stays 0; L=15 with PAT_W=8 -> behaves as L=8.
REQ-037 SHALL cover: rst asserted after bits 0,1,1 of pattern 0110 -> z=0 and match_cnt=0 immediately; after release and cfg_load, a single trailing 0 produces no match.
